// File: rtl/jlsemi_util_clk_gate_ctrl.sv
// Auto clock-gating controller for the ADC capture path.
// Drives E/TE of the gating cell and flags when the gated clock is usable.
module jlsemi_util_clk_gate_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              auto_en,
  input  logic              force_on,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              scan_mode,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic              cnt_clr,
  output logic              gate_en,
  output logic              gate_te,
  output logic              clk_ready,
  output logic [CNT_W-1:0]  wake_cnt
);

  localparam int TMR_W =
    (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  localparam logic [1:0] ST_ON   = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_WAKE = 2'd2;

  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(WAKE_CYC - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_cnt_nxt;
  logic [IDLE_W:0]   idle_inc;
  logic [TMR_W-1:0]  wake_tmr;
  logic [TMR_W-1:0]  wake_tmr_nxt;
  logic              gate_en_nxt;
  logic              clk_ready_nxt;
  logic              active;
  logic              idle_hit;
  logic              wake_go;
  logic              wake_done;

  assign active = busy | wake_req | force_on | ~auto_en
                | (cfg_idle_thr == '0);

  // widened so idle_cnt+1 cannot wrap before the compare
  assign idle_inc = {1'b0, idle_cnt}
                  + {{IDLE_W{1'b0}}, 1'b1};
  assign idle_hit = idle_inc >= {1'b0, cfg_idle_thr};

  assign wake_go   = (state == ST_OFF) & active;
  assign wake_done = (state == ST_WAKE)
                   & (wake_tmr == TMR_LAST);

  assign gate_te = scan_mode;

  always_comb begin
    state_nxt     = state;
    idle_cnt_nxt  = idle_cnt;
    wake_tmr_nxt  = wake_tmr;
    gate_en_nxt   = gate_en;
    clk_ready_nxt = clk_ready;
    unique case (state)
      ST_ON: begin
        gate_en_nxt   = 1'b1;
        clk_ready_nxt = 1'b1;
        if (active) begin
          idle_cnt_nxt = '0;
        end else if (idle_hit) begin
          state_nxt     = ST_OFF;
          idle_cnt_nxt  = '0;
          gate_en_nxt   = 1'b0;
          clk_ready_nxt = 1'b0;
        end else if (idle_cnt != '1) begin
          idle_cnt_nxt = idle_inc[IDLE_W-1:0];
        end
      end
      ST_OFF: begin
        gate_en_nxt   = 1'b0;
        clk_ready_nxt = 1'b0;
        if (active) begin
          state_nxt    = ST_WAKE;
          wake_tmr_nxt = '0;
          gate_en_nxt  = 1'b1;
        end
      end
      ST_WAKE: begin
        gate_en_nxt   = 1'b1;
        clk_ready_nxt = 1'b0;
        if (wake_done) begin
          state_nxt     = ST_ON;
          wake_tmr_nxt  = '0;
          idle_cnt_nxt  = '0;
          clk_ready_nxt = 1'b1;
        end else begin
          wake_tmr_nxt = wake_tmr + 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_ON;
        idle_cnt_nxt  = '0;
        wake_tmr_nxt  = '0;
        gate_en_nxt   = 1'b1;
        clk_ready_nxt = 1'b1;
      end
    endcase
  end

  // reset lands in ON: a running clock is the safe default
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ON;
      idle_cnt  <= '0;
      wake_tmr  <= '0;
      gate_en   <= 1'b1;
      clk_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_cnt_nxt;
      wake_tmr  <= wake_tmr_nxt;
      gate_en   <= gate_en_nxt;
      clk_ready <= clk_ready_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt <= '0;
    end else if (cnt_clr) begin
      wake_cnt <= '0;
    end else if (wake_go && wake_cnt != '1) begin
      wake_cnt <= wake_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jlsemi_util_clk_gate_ctrl.sv
// Bench for jlsemi_util_clk_gate_ctrl: vector table with
// scoreboard plus hand sequences for long/async corners.
module tb_jlsemi_util_clk_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        auto_en;
  logic        force_on;
  logic        busy;
  logic        wake_req;
  logic        scan_mode;
  logic [7:0]  thr;
  logic        cnt_clr;
  logic        gate_en;
  logic        gate_te;
  logic        clk_ready;
  logic [15:0] wake_cnt;

  logic        s_clr;
  logic        s_gate_en;
  logic        s_gate_te;
  logic        s_clk_ready;
  logic [2:0]  s_wake_cnt;

  int passed;
  int total;

  jlsemi_util_clk_gate_ctrl #(
    .IDLE_W(8), .WAKE_CYC(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en),
    .force_on(force_on), .busy(busy),
    .wake_req(wake_req), .scan_mode(scan_mode),
    .cfg_idle_thr(thr), .cnt_clr(cnt_clr),
    .gate_en(gate_en), .gate_te(gate_te),
    .clk_ready(clk_ready), .wake_cnt(wake_cnt)
  );

  // small counter width so saturation is reachable quickly
  jlsemi_util_clk_gate_ctrl #(
    .IDLE_W(8), .WAKE_CYC(2), .CNT_W(3)
  ) sat_dut (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en),
    .force_on(force_on), .busy(busy),
    .wake_req(wake_req), .scan_mode(scan_mode),
    .cfg_idle_thr(thr), .cnt_clr(s_clr),
    .gate_en(s_gate_en), .gate_te(s_gate_te),
    .clk_ready(s_clk_ready), .wake_cnt(s_wake_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        b;
    logic        w;
    logic        f;
    logic        a;
    logic        c;
    logic [7:0]  t;
    logic        eg;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    logic        g;
    logic        r;
    logic [15:0] c;
    int          id;
  } exp_t;

  vec_t vq[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic b, input logic w, input logic f,
    input logic a, input logic c, input logic [7:0] t,
    input logic eg, input logic er, input logic [15:0] ec
  );
    vec_t v;
    v.b = b; v.w = w; v.f = f; v.a = a; v.c = c;
    v.t = t; v.eg = eg; v.er = er; v.ec = ec;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    else
      passed++;
  endtask

  task automatic cyc(input logic b);
    busy = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    exp_t e;
    passed = 0; total = 0;
    rst_n = 1'b0; auto_en = 1'b1; force_on = 1'b0;
    busy = 1'b0; wake_req = 1'b0; scan_mode = 1'b0;
    thr = 8'd4; cnt_clr = 1'b0; s_clr = 1'b0;

    // b w f a c thr  gate ready cnt
    vq.push_back(mk(0,0,0,1,0,4, 1,1,0));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,0));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,0));
    vq.push_back(mk(0,0,0,1,0,4, 0,0,0));
    vq.push_back(mk(0,0,0,1,0,4, 0,0,0));
    vq.push_back(mk(1,0,0,1,0,4, 1,0,1));
    vq.push_back(mk(0,0,0,1,0,4, 1,0,1));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,1));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,1));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,1));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,1));
    vq.push_back(mk(0,0,0,1,0,4, 0,0,1));
    vq.push_back(mk(0,1,0,1,0,4, 1,0,2));
    vq.push_back(mk(0,1,0,1,0,4, 1,0,2));
    vq.push_back(mk(0,1,0,1,0,4, 1,1,2));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
    vq.push_back(mk(1,0,0,1,0,4, 1,1,2));
    for (int k = 0; k < 4; k++) begin
      vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
      vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
      vq.push_back(mk(1,0,0,1,0,4, 1,1,2));
    end
    vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
    vq.push_back(mk(0,0,0,1,0,4, 1,1,2));
    vq.push_back(mk(0,0,0,1,0,2, 0,0,2));
    vq.push_back(mk(0,0,0,1,0,2, 0,0,2));
    vq.push_back(mk(0,0,1,1,0,2, 1,0,3));
    vq.push_back(mk(0,0,0,1,0,2, 1,0,3));
    vq.push_back(mk(0,0,0,1,0,2, 1,1,3));
    vq.push_back(mk(0,0,0,1,0,2, 1,1,3));
    vq.push_back(mk(0,0,0,1,0,2, 0,0,3));
    vq.push_back(mk(1,0,0,1,1,2, 1,0,0));
    vq.push_back(mk(0,0,0,1,0,2, 1,0,0));
    vq.push_back(mk(0,0,0,1,0,2, 1,1,0));
    vq.push_back(mk(0,0,0,0,0,2, 1,1,0));
    vq.push_back(mk(0,0,0,1,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,1));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,1));
    vq.push_back(mk(0,0,0,0,0,1, 1,1,1));
    vq.push_back(mk(0,0,0,1,0,0, 1,1,1));
    vq.push_back(mk(0,0,0,1,1,0, 1,1,0));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_gate_en", gate_en, 1);
    chk("rst_clk_ready", clk_ready, 1);
    chk("rst_wake_cnt", wake_cnt, 0);

    for (int i = 0; i < vq.size(); i++) begin
      busy = vq[i].b; wake_req = vq[i].w;
      force_on = vq[i].f; auto_en = vq[i].a;
      cnt_clr = vq[i].c; thr = vq[i].t;
      e.g = vq[i].eg; e.r = vq[i].er;
      e.c = vq[i].ec; e.id = i;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("row%0d_gate_en", e.id), gate_en, e.g);
      chk($sformatf("row%0d_clk_ready", e.id),
          clk_ready, e.r);
      chk($sformatf("row%0d_wake_cnt", e.id), wake_cnt, e.c);
    end
    busy = 1'b0; wake_req = 1'b0; force_on = 1'b0;
    cnt_clr = 1'b0;

    // long idle stretches that must never gate
    bad = 0; thr = 8'd0; auto_en = 1'b1;
    for (int i = 0; i < 334; i++) begin
      cyc(0);
      if (gate_en !== 1'b1 || clk_ready !== 1'b1) bad++;
    end
    chk("hold_thr0", bad, 0);
    bad = 0; thr = 8'd4; auto_en = 1'b0;
    for (int i = 0; i < 333; i++) begin
      cyc(0);
      if (gate_en !== 1'b1 || clk_ready !== 1'b1) bad++;
    end
    chk("hold_auto_off", bad, 0);
    bad = 0; auto_en = 1'b1; force_on = 1'b1;
    for (int i = 0; i < 333; i++) begin
      cyc(0);
      if (gate_en !== 1'b1 || clk_ready !== 1'b1) bad++;
    end
    chk("hold_force_on", bad, 0);

    // all-ones threshold gates on the 255th idle edge
    force_on = 1'b0; thr = 8'hFF;
    repeat (254) cyc(0);
    chk("thr_ff_edge254", gate_en, 1);
    cyc(0);
    chk("thr_ff_edge255", gate_en, 0);
    cyc(1);
    chk("thr_ff_wake_gate", gate_en, 1);
    chk("thr_ff_wake_rdy", clk_ready, 0);
    cyc(0);
    chk("thr_ff_wake_rdy1", clk_ready, 0);
    cyc(0);
    chk("thr_ff_on_rdy", clk_ready, 1);

    // three more wakes: 9 total, small counter pinned at 7
    thr = 8'd1;
    for (int k = 0; k < 3; k++) begin
      cyc(0);
      cyc(1);
      cyc(0);
      cyc(0);
    end
    chk("sat_cnt", s_wake_cnt, 3'd7);
    chk("main_cnt", wake_cnt, 16'd4);

    scan_mode = 1'b1;
    cyc(0);
    chk("scan_off_te", gate_te, 1);
    chk("scan_off_gate", gate_en, 0);
    cyc(1);
    chk("scan_wake_te", gate_te, 1);
    chk("scan_wake_rdy", clk_ready, 0);
    chk("scan_wake_cnt", wake_cnt, 16'd5);

    // async reset between edges while in WAKE
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate_en", gate_en, 1);
    chk("arst_clk_ready", clk_ready, 1);
    chk("arst_wake_cnt", wake_cnt, 0);
    chk("arst_sat_cnt", s_wake_cnt, 0);
    scan_mode = 1'b0;
    #1;
    chk("scan_low_te", gate_te, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
